// File: rtl/fifo_pkg.sv
// Shared types and default sizes for the FIFO burst reader.
package fifo_pkg;

    localparam int unsigned FIFO_DATA_W         = 8;
    localparam int unsigned FIFO_LEN_W          = 8;
    localparam int unsigned FIFO_TIMEOUT_CYCLES = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        FIN   = 2'd3
    } state_e;

endpackage

// File: rtl/fifo_burst_reader_out_stage.sv
// One-entry valid/ready output register for the burst reader stream.
module out_stage
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = FIFO_DATA_W
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  load_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  ready_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  valid_o,
    output logic                  can_accept_c_o,
    output logic                  hs_c_o
);

    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  valid_q, valid_d;

    // Slot is free when empty or when its byte leaves this cycle.
    assign hs_c_o         = valid_q & ready_i;
    assign can_accept_c_o = ~valid_q | ready_i;

    // Load wins over drain so a pop during a handshake keeps valid high.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        if (load_i) begin
            data_d  = data_i;
            valid_d = 1'b1;
        end else if (valid_q & ready_i) begin
            valid_d = 1'b0;
        end
    end

    // Output register with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/fifo_burst_reader.sv
// Read-side burst controller for the 8-bit async FIFO (read clock domain).
// Optional starvation timeout is compiled in with BURST_TIMEOUT_EN.
module fifo_burst_reader
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = FIFO_DATA_W,
    parameter int unsigned LEN_WIDTH      = FIFO_LEN_W
`ifdef BURST_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYCLES = FIFO_TIMEOUT_CYCLES
`endif
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  EMPTY_flag,
    input  logic [DATA_WIDTH-1:0] FIFO_DATA,
    output logic                  R_EN,
    input  logic                  START,
    input  logic [LEN_WIDTH-1:0]  LEN,
    output logic                  BUSY,
    output logic [DATA_WIDTH-1:0] OUT_DATA,
    output logic                  OUT_VALID,
    input  logic                  OUT_READY,
    output logic                  DONE,
    output logic [LEN_WIDTH-1:0]  XFER_CNT
`ifdef BURST_TIMEOUT_EN
    ,
    output logic                  TIMEOUT
`endif
);

    state_e                state_q, state_d;
    logic [LEN_WIDTH-1:0]  remaining_q, remaining_d;
    logic [LEN_WIDTH-1:0]  xfer_cnt_q, xfer_cnt_d;
    logic                  done_q, done_d;
    logic                  busy_q, busy_d;

    logic                  can_accept_c;
    logic                  hs_c;
    logic                  pop_c;
    logic                  to_hit_c;
    logic                  start_c;

    // Output byte register and handshake detection.
    out_stage #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_out_stage (
        .clk_i          (CLK),
        .rst_ni         (RST),
        .load_i         (pop_c),
        .data_i         (FIFO_DATA),
        .ready_i        (OUT_READY),
        .data_o         (OUT_DATA),
        .valid_o        (OUT_VALID),
        .can_accept_c_o (can_accept_c),
        .hs_c_o         (hs_c)
    );

    assign start_c = (state_q == IDLE) & START;

    // Pop only in RUN with data available, bytes owed and a free output slot.
    assign pop_c = (state_q == RUN) & ~EMPTY_flag & (remaining_q != '0)
                 & can_accept_c & ~to_hit_c;
    assign R_EN  = pop_c;

    // Next-state and counter logic.
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        xfer_cnt_d  = xfer_cnt_q;
        if (hs_c) begin
            xfer_cnt_d = xfer_cnt_q + LEN_WIDTH'(1);
        end
        case (state_q)
            IDLE: begin
                if (START) begin
                    remaining_d = LEN;
                    xfer_cnt_d  = '0;
                    state_d     = (LEN != '0) ? RUN : FIN;
                end
            end
            RUN: begin
                if (to_hit_c) begin
                    // A byte still waiting downstream must drain first.
                    state_d = (OUT_VALID & ~hs_c) ? DRAIN : FIN;
                end else if (pop_c) begin
                    remaining_d = remaining_q - LEN_WIDTH'(1);
                    if (remaining_q == LEN_WIDTH'(1)) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (hs_c) begin
                    state_d = FIN;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        done_d = (state_q == FIN);
        busy_d = (state_d != IDLE);
    end

    // FSM state and counter registers.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            xfer_cnt_q  <= '0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            xfer_cnt_q  <= xfer_cnt_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
        end
    end

    assign BUSY     = busy_q;
    assign DONE     = done_q;
    assign XFER_CNT = xfer_cnt_q;

`ifdef BURST_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TO_W-1:0] starve_q, starve_d;
    logic            to_flag_q, to_flag_d;
    logic            timeout_q, timeout_d;

    assign to_hit_c = (state_q == RUN) & (starve_q == TO_W'(TIMEOUT_CYCLES));

    // Starvation counter; the sticky flag surfaces on TIMEOUT with DONE.
    always_comb begin
        starve_d  = starve_q;
        to_flag_d = to_flag_q;
        timeout_d = timeout_q;
        if (start_c) begin
            starve_d  = '0;
            to_flag_d = 1'b0;
            timeout_d = 1'b0;
        end else if (state_q == RUN) begin
            if (to_hit_c) begin
                to_flag_d = 1'b1;
            end else if (pop_c) begin
                starve_d = '0;
            end else if (EMPTY_flag) begin
                starve_d = starve_q + TO_W'(1);
            end
        end else if ((state_q == FIN) & to_flag_q) begin
            timeout_d = 1'b1;
        end
    end

    // Starvation registers.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            starve_q  <= '0;
            to_flag_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            starve_q  <= starve_d;
            to_flag_q <= to_flag_d;
            timeout_q <= timeout_d;
        end
    end

    assign TIMEOUT = timeout_q;
`else
    assign to_hit_c = 1'b0;

    // START qualification only matters for the timeout logic.
    logic unused_c;
    assign unused_c = start_c;
`endif

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Directed self-checking bench for fifo_burst_reader with a show-ahead FIFO model.
module tb_fifo_burst_reader;

    logic       CLK = 1'b0;
    logic       RST;
    logic       EMPTY_flag;
    logic [7:0] FIFO_DATA;
    logic       R_EN;
    logic       START;
    logic [7:0] LEN;
    logic       BUSY;
    logic [7:0] OUT_DATA;
    logic       OUT_VALID;
    logic       OUT_READY;
    logic       DONE;
    logic [7:0] XFER_CNT;
`ifdef BURST_TIMEOUT_EN
    logic       TIMEOUT;
    logic       done_to;
`endif

    fifo_burst_reader dut (
        .CLK        (CLK),
        .RST        (RST),
        .EMPTY_flag (EMPTY_flag),
        .FIFO_DATA  (FIFO_DATA),
        .R_EN       (R_EN),
        .START      (START),
        .LEN        (LEN),
        .BUSY       (BUSY),
        .OUT_DATA   (OUT_DATA),
        .OUT_VALID  (OUT_VALID),
        .OUT_READY  (OUT_READY),
        .DONE       (DONE),
        .XFER_CNT   (XFER_CNT)
`ifdef BURST_TIMEOUT_EN
        ,
        .TIMEOUT    (TIMEOUT)
`endif
    );

    always #5 CLK = ~CLK;

    int checks   = 0;
    int failures = 0;

    int cyc_n = 0;
    int start_cyc, n_ren, first_ren, last_ren, n_done, done_cyc, done_xfer, last_hs, n_busy;
    logic       stall_prev = 1'b0;
    logic [7:0] prev_data  = 8'h00;
    logic [7:0] fq[$];
    logic [7:0] acc[$];
    logic [7:0] exp_q[$];

    task automatic clear_mon();
        start_cyc = cyc_n;
        n_ren     = 0;
        first_ren = -1;
        last_ren  = -1;
        n_done    = 0;
        done_cyc  = -1;
        done_xfer = -1;
        last_hs   = -1;
        n_busy    = 0;
        acc.delete();
`ifdef BURST_TIMEOUT_EN
        done_to = 1'b0;
`endif
    endtask

    // One clock cycle: present FIFO head, observe outputs, advance FIFO model on pop.
    task automatic cyc();
        logic pop_now;
        EMPTY_flag = (fq.size() == 0);
        FIFO_DATA  = (fq.size() == 0) ? 8'h00 : fq[0];
        #1;
        if (EMPTY_flag) begin
            checks++;
            if (R_EN !== 1'b0) begin
                failures++;
                $display("FAIL ren_while_empty: cycle %0d R_EN=%b required 0", cyc_n, R_EN);
            end
        end
        if (stall_prev) begin
            checks++;
            if (OUT_VALID !== 1'b1 || OUT_DATA !== prev_data) begin
                failures++;
                $display("FAIL stall_hold: cycle %0d valid=%b data=%h required valid=1 data=%h",
                         cyc_n, OUT_VALID, OUT_DATA, prev_data);
            end
        end
        if (OUT_VALID && !OUT_READY) begin
            checks++;
            if (R_EN !== 1'b0) begin
                failures++;
                $display("FAIL ren_while_stalled: cycle %0d R_EN=%b required 0", cyc_n, R_EN);
            end
        end
        if (R_EN === 1'b1) begin
            n_ren++;
            if (first_ren < 0) first_ren = cyc_n;
            last_ren = cyc_n;
        end
        if (OUT_VALID === 1'b1 && OUT_READY) begin
            acc.push_back(OUT_DATA);
            last_hs = cyc_n;
        end
        if (DONE === 1'b1) begin
            n_done++;
            done_cyc  = cyc_n;
            done_xfer = int'(XFER_CNT);
`ifdef BURST_TIMEOUT_EN
            done_to = TIMEOUT;
`endif
            checks++;
            if (BUSY !== 1'b0) begin
                failures++;
                $display("FAIL busy_with_done: cycle %0d BUSY=%b required 0", cyc_n, BUSY);
            end
        end
        if (BUSY === 1'b1) n_busy++;
        stall_prev = (OUT_VALID === 1'b1) && !OUT_READY;
        prev_data  = OUT_DATA;
        pop_now    = (R_EN === 1'b1);
        @(posedge CLK);
        if (pop_now && fq.size() != 0) void'(fq.pop_front());
        cyc_n++;
        @(negedge CLK);
    endtask

    // Issue START and run until DONE; stall_mask bit i drops OUT_READY in burst cycle i.
    task automatic run_burst(input int len, input int budget, input logic [31:0] stall_mask,
                             input int restart_at);
        clear_mon();
        for (int i = 0; i < budget && n_done == 0; i++) begin
            OUT_READY = (i < 32) ? !stall_mask[i] : 1'b1;
            START     = (i == 0) || (i == restart_at);
            LEN       = (i == restart_at) ? 8'd2 : 8'(len);
            cyc();
        end
        START     = 1'b0;
        OUT_READY = 1'b1;
        checks++;
        if (n_done != 1) begin
            failures++;
            $display("FAIL burst_done: len %0d DONE pulses=%0d required 1 within %0d cycles",
                     len, n_done, budget);
        end
    endtask

    task automatic test_reset();
        RST = 1'b0;
        repeat (2) cyc();
        RST = 1'b1;
        checks += 6;
        if (R_EN !== 1'b0)      begin failures++; $display("FAIL reset_r_en: got %b required 0", R_EN); end
        if (OUT_VALID !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b required 0", OUT_VALID); end
        if (OUT_DATA !== 8'h00) begin failures++; $display("FAIL reset_out_data: got %h required 00", OUT_DATA); end
        if (DONE !== 1'b0)      begin failures++; $display("FAIL reset_done: got %b required 0", DONE); end
        if (BUSY !== 1'b0)      begin failures++; $display("FAIL reset_busy: got %b required 0", BUSY); end
        if (XFER_CNT !== 8'd0)  begin failures++; $display("FAIL reset_xfer_cnt: got %0d required 0", XFER_CNT); end
    endtask

    task automatic test_basic();
        fq    = '{8'h11, 8'h12, 8'h13, 8'h14};
        exp_q = '{8'h11, 8'h12, 8'h13, 8'h14};
        run_burst(4, 40, 32'h0, -1);
        checks += 4;
        if (n_ren != 4) begin failures++; $display("FAIL basic_pops: got %0d required 4", n_ren); end
        if (last_ren - first_ren != 3) begin
            failures++; $display("FAIL basic_pop_span: got %0d required 3", last_ren - first_ren);
        end
        if (done_xfer != 4) begin failures++; $display("FAIL basic_xfer: got %0d required 4", done_xfer); end
        if (done_cyc - last_hs != 2) begin
            failures++; $display("FAIL basic_done_delay: got %0d required 2", done_cyc - last_hs);
        end
        checks++;
        if (acc.size() != exp_q.size()) begin
            failures++; $display("FAIL basic_len: got %0d required %0d", acc.size(), exp_q.size());
        end
        for (int k = 0; k < acc.size() && k < exp_q.size(); k++) begin
            checks++;
            if (acc[k] !== exp_q[k]) begin
                failures++; $display("FAIL basic_byte%0d: got %h required %h", k, acc[k], exp_q[k]);
            end
        end
        repeat (2) cyc();
        checks += 2;
        if (n_done != 1) begin failures++; $display("FAIL basic_done_pulse: got %0d required 1", n_done); end
        if (XFER_CNT !== 8'd4) begin failures++; $display("FAIL basic_xfer_hold: got %0d required 4", XFER_CNT); end
    endtask

    task automatic test_len_zero();
        fq = '{8'h55};
        run_burst(0, 20, 32'h0, -1);
        checks += 4;
        if (n_ren != 0) begin failures++; $display("FAIL zero_pops: got %0d required 0", n_ren); end
        if (n_busy != 1) begin failures++; $display("FAIL zero_busy: got %0d required 1", n_busy); end
        if (done_xfer != 0) begin failures++; $display("FAIL zero_xfer: got %0d required 0", done_xfer); end
        if (done_cyc - start_cyc != 2) begin
            failures++; $display("FAIL zero_done_delay: got %0d required 2", done_cyc - start_cyc);
        end
        fq.delete();
    endtask

    task automatic test_stall();
        fq    = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38};
        exp_q = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38};
        run_burst(8, 60, 32'h0000_0018, -1);
        checks += 2;
        if (n_ren != 8) begin failures++; $display("FAIL stall_pops: got %0d required 8", n_ren); end
        if (done_xfer != 8) begin failures++; $display("FAIL stall_xfer: got %0d required 8", done_xfer); end
        checks++;
        if (acc.size() != exp_q.size()) begin
            failures++; $display("FAIL stall_len: got %0d required %0d", acc.size(), exp_q.size());
        end
        for (int k = 0; k < acc.size() && k < exp_q.size(); k++) begin
            checks++;
            if (acc[k] !== exp_q[k]) begin
                failures++; $display("FAIL stall_byte%0d: got %h required %h", k, acc[k], exp_q[k]);
            end
        end
    endtask

    task automatic test_start_ignored();
        fq    = '{8'h41, 8'h42, 8'h43, 8'h44};
        exp_q = '{8'h41, 8'h42, 8'h43, 8'h44};
        run_burst(4, 40, 32'h0, 2);
        checks += 2;
        if (n_ren != 4) begin failures++; $display("FAIL restart_pops: got %0d required 4", n_ren); end
        if (done_xfer != 4) begin failures++; $display("FAIL restart_xfer: got %0d required 4", done_xfer); end
        checks++;
        if (acc.size() != exp_q.size()) begin
            failures++; $display("FAIL restart_len: got %0d required %0d", acc.size(), exp_q.size());
        end
        for (int k = 0; k < acc.size() && k < exp_q.size(); k++) begin
            checks++;
            if (acc[k] !== exp_q[k]) begin
                failures++; $display("FAIL restart_byte%0d: got %h required %h", k, acc[k], exp_q[k]);
            end
        end
        cyc();
        checks++;
        if (BUSY !== 1'b0) begin failures++; $display("FAIL restart_idle: BUSY=%b required 0", BUSY); end
    endtask

    task automatic test_max_len();
        fq.delete();
        exp_q.delete();
        for (int k = 0; k < 255; k++) begin
            fq.push_back(8'(k + 7));
            exp_q.push_back(8'(k + 7));
        end
        run_burst(255, 400, 32'h0, -1);
        checks += 3;
        if (n_ren != 255) begin failures++; $display("FAIL max_pops: got %0d required 255", n_ren); end
        if (last_ren - first_ren != 254) begin
            failures++; $display("FAIL max_pop_span: got %0d required 254", last_ren - first_ren);
        end
        if (done_xfer != 255) begin failures++; $display("FAIL max_xfer: got %0d required 255", done_xfer); end
        checks++;
        if (acc.size() != exp_q.size()) begin
            failures++; $display("FAIL max_len: got %0d required %0d", acc.size(), exp_q.size());
        end
        for (int k = 0; k < acc.size() && k < exp_q.size(); k++) begin
            checks++;
            if (acc[k] !== exp_q[k]) begin
                failures++; $display("FAIL max_byte%0d: got %h required %h", k, acc[k], exp_q[k]);
            end
        end
    endtask

    task automatic test_starve();
        fq = '{8'h21, 8'h22, 8'h23};
        clear_mon();
        OUT_READY = 1'b1;
        START     = 1'b1;
        LEN       = 8'd5;
        cyc();
        START = 1'b0;
        repeat (12) cyc();
        checks += 4;
        if (n_ren != 3) begin failures++; $display("FAIL starve_pops: got %0d required 3", n_ren); end
        if (BUSY !== 1'b1) begin failures++; $display("FAIL starve_busy: got %b required 1", BUSY); end
        if (n_done != 0) begin failures++; $display("FAIL starve_no_done: got %0d required 0", n_done); end
        if (XFER_CNT !== 8'd3) begin failures++; $display("FAIL starve_xfer: got %0d required 3", XFER_CNT); end
`ifdef BURST_TIMEOUT_EN
        for (int i = 0; i < 100 && n_done == 0; i++) cyc();
        checks += 4;
        if (n_done != 1) begin failures++; $display("FAIL timeout_done: got %0d required 1", n_done); end
        if (done_to !== 1'b1) begin failures++; $display("FAIL timeout_flag: got %b required 1", done_to); end
        if (done_xfer != 3) begin failures++; $display("FAIL timeout_xfer: got %0d required 3", done_xfer); end
        if (n_ren != 3) begin failures++; $display("FAIL timeout_pops: got %0d required 3", n_ren); end
        cyc();
        checks++;
        if (TIMEOUT !== 1'b1) begin failures++; $display("FAIL timeout_sticky: got %b required 1", TIMEOUT); end
        run_burst(0, 20, 32'h0, -1);
        checks++;
        if (done_to !== 1'b0) begin failures++; $display("FAIL timeout_clear: got %b required 0", done_to); end
`else
        fq.push_back(8'h24);
        fq.push_back(8'h25);
        exp_q = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25};
        for (int i = 0; i < 20 && n_done == 0; i++) cyc();
        checks += 3;
        if (n_done != 1) begin failures++; $display("FAIL starve_done: got %0d required 1", n_done); end
        if (n_ren != 5) begin failures++; $display("FAIL starve_total_pops: got %0d required 5", n_ren); end
        if (done_xfer != 5) begin failures++; $display("FAIL starve_final_xfer: got %0d required 5", done_xfer); end
        checks++;
        if (acc.size() != exp_q.size()) begin
            failures++; $display("FAIL starve_len: got %0d required %0d", acc.size(), exp_q.size());
        end
        for (int k = 0; k < acc.size() && k < exp_q.size(); k++) begin
            checks++;
            if (acc[k] !== exp_q[k]) begin
                failures++; $display("FAIL starve_byte%0d: got %h required %h", k, acc[k], exp_q[k]);
            end
        end
`endif
        fq.delete();
    endtask

    task automatic test_reset_mid();
        fq = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
        clear_mon();
        OUT_READY = 1'b1;
        START     = 1'b1;
        LEN       = 8'd6;
        cyc();
        START = 1'b0;
        repeat (2) cyc();
        checks++;
        if (n_ren != 2) begin failures++; $display("FAIL midrst_pre_pops: got %0d required 2", n_ren); end
        RST = 1'b0;
        cyc();
        RST = 1'b1;
        checks += 6;
        if (R_EN !== 1'b0)      begin failures++; $display("FAIL midrst_r_en: got %b required 0", R_EN); end
        if (OUT_VALID !== 1'b0) begin failures++; $display("FAIL midrst_out_valid: got %b required 0", OUT_VALID); end
        if (OUT_DATA !== 8'h00) begin failures++; $display("FAIL midrst_out_data: got %h required 00", OUT_DATA); end
        if (DONE !== 1'b0)      begin failures++; $display("FAIL midrst_done: got %b required 0", DONE); end
        if (BUSY !== 1'b0)      begin failures++; $display("FAIL midrst_busy: got %b required 0", BUSY); end
        if (XFER_CNT !== 8'd0)  begin failures++; $display("FAIL midrst_xfer: got %0d required 0", XFER_CNT); end
        clear_mon();
        repeat (4) cyc();
        checks += 2;
        if (n_done != 0) begin failures++; $display("FAIL midrst_no_done: got %0d required 0", n_done); end
        if (n_ren != 0) begin failures++; $display("FAIL midrst_idle_pops: got %0d required 0", n_ren); end
        exp_q = fq;
        run_burst(exp_q.size(), 40, 32'h0, -1);
        checks++;
        if (done_xfer != exp_q.size()) begin
            failures++; $display("FAIL midrst_new_xfer: got %0d required %0d", done_xfer, exp_q.size());
        end
        checks++;
        if (acc.size() != exp_q.size()) begin
            failures++; $display("FAIL midrst_len: got %0d required %0d", acc.size(), exp_q.size());
        end
        for (int k = 0; k < acc.size() && k < exp_q.size(); k++) begin
            checks++;
            if (acc[k] !== exp_q[k]) begin
                failures++; $display("FAIL midrst_byte%0d: got %h required %h", k, acc[k], exp_q[k]);
            end
        end
    endtask

    initial begin
        RST        = 1'b0;
        START      = 1'b0;
        LEN        = 8'd0;
        OUT_READY  = 1'b1;
        EMPTY_flag = 1'b1;
        FIFO_DATA  = 8'h00;
        clear_mon();
        @(negedge CLK);
        test_reset();
        test_basic();
        test_len_zero();
        test_stall();
        test_start_ignored();
        test_max_len();
        test_starve();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
